// File: rtl/result_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle, with a held result register.
// Optional: define RESULT_BCD_CONVERTER_AUTO_START_EN to start automatically whenever value changes.
module result_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   scratch_q, scratch_d, adj;
  logic [4*DIGITS-1:0]   bcd_q;
  logic [WIDTH-1:0]      bin_q, bin_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q;
  logic                  accept;

`ifdef RESULT_BCD_CONVERTER_AUTO_START_EN
  logic [WIDTH-1:0]      last_value_q;

  assign accept = start || (value != last_value_q);

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_value_q <= '0;
    end else if (state_q == IDLE && accept) begin
      last_value_q <= value;
    end
  end
`else
  assign accept = start;
`endif

  // Add-3 correction applied to every digit before each shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ?
                              scratch_q[4*gi +: 4] + 4'd3 : scratch_q[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_comb begin
    scratch_d = scratch_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          scratch_d = '0;
          bin_d     = value;
          cnt_d     = '0;
        end
      end
      SHIFT: begin
        scratch_d = {adj[4*DIGITS-2:0], bin_q[WIDTH-1]};
        bin_d     = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      scratch_q <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      done_q    <= (state_q == DONE);
      if (state_q == DONE) begin
        bcd_q <= scratch_q;
      end
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;

endmodule
